// File: rtl/spi_pkg.sv
// Shared types and constants for the mode-0 SPI responder.
package spi_pkg;
    typedef enum logic {IDLE, SHIFT} state_t;

    localparam int SPI_WIDTH = 8;
    localparam logic [SPI_WIDTH-1:0] TX_IDLE_FILL = 8'h00;
endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin, with one extra flop for rise/fall detection.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync;
    logic              prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= {STAGES{RST_VAL}};
            prev <= RST_VAL;
        end else begin
            sync <= {sync[STAGES-2:0], din};
            prev <= sync[STAGES-1];
        end
    end

    assign q    = sync[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;
endmodule

// File: rtl/spi_slave.sv
// Mode-0 SPI responder with a one-entry tx buffer for multi-byte frames.
// Optional sticky tx_underrun output when SPI_SLAVE_UNDERRUN_EN is defined.
module spi_slave
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sck,
    input  logic                 cs_n,
    input  logic                 mosi,
    output logic                 miso,
    output logic                 miso_oe,
    input  logic [SPI_WIDTH-1:0] tx_data,
    input  logic                 tx_load,
    output logic                 tx_ready,
    output logic [SPI_WIDTH-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 busy
`ifdef SPI_SLAVE_UNDERRUN_EN
    ,
    output logic                 tx_underrun
`endif
);
    logic sck_level_unused, sck_rise, sck_fall;
    logic cs_sync, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_pipe;
    logic mosi_sync;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
        .clk(clk), .rst_n(rst_n), .din(sck),
        .q(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk(clk), .rst_n(rst_n), .din(cs_n),
        .q(cs_sync), .rise(cs_rise), .fall(cs_fall)
    );

    // Same depth as sck so mosi_sync lines up with the detected rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mosi_pipe <= '0;
        else        mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], mosi};
    end
    assign mosi_sync = mosi_pipe[SYNC_STAGES-1];

    state_t               state, state_n;
    logic [2:0]           bit_cnt, bit_cnt_n;
    logic [SPI_WIDTH-1:0] shift_rx, shift_rx_n, shift_tx, shift_tx_n;
    logic [SPI_WIDTH-1:0] rx_data_n, tx_buf, tx_next;
    logic                 miso_n, rx_valid_n, byte_boundary, byte_boundary_n;
    logic                 tx_full, consume, load_ok;

    assign tx_next = tx_full ? tx_buf : TX_IDLE_FILL;
    assign load_ok = tx_load & ~tx_full;

    always_comb begin
        state_n         = state;
        bit_cnt_n       = bit_cnt;
        shift_rx_n      = shift_rx;
        shift_tx_n      = shift_tx;
        miso_n          = miso;
        byte_boundary_n = byte_boundary;
        rx_data_n       = rx_data;
        rx_valid_n      = 1'b0;
        consume         = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_n         = SHIFT;
                    consume         = 1'b1;
                    shift_tx_n      = tx_next;
                    miso_n          = tx_next[SPI_WIDTH-1];
                    bit_cnt_n       = 3'd0;
                    byte_boundary_n = 1'b0;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_n         = IDLE;
                    bit_cnt_n       = 3'd0;
                    miso_n          = 1'b0;
                    byte_boundary_n = 1'b0;
                end else if (sck_rise) begin
                    shift_rx_n = {shift_rx[SPI_WIDTH-2:0], mosi_sync};
                    bit_cnt_n  = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        rx_data_n       = {shift_rx[SPI_WIDTH-2:0], mosi_sync};
                        rx_valid_n      = 1'b1;
                        byte_boundary_n = 1'b1;
                    end
                end else if (sck_fall) begin
                    if (byte_boundary) begin
                        consume         = 1'b1;
                        shift_tx_n      = tx_next;
                        miso_n          = tx_next[SPI_WIDTH-1];
                        byte_boundary_n = 1'b0;
                    end else begin
                        shift_tx_n = {shift_tx[SPI_WIDTH-2:0], 1'b0};
                        miso_n     = shift_tx[SPI_WIDTH-2];
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bit_cnt       <= 3'd0;
            shift_rx      <= '0;
            shift_tx      <= '0;
            miso          <= 1'b0;
            byte_boundary <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
        end else begin
            state         <= state_n;
            bit_cnt       <= bit_cnt_n;
            shift_rx      <= shift_rx_n;
            shift_tx      <= shift_tx_n;
            miso          <= miso_n;
            byte_boundary <= byte_boundary_n;
            rx_data       <= rx_data_n;
            rx_valid      <= rx_valid_n;
        end
    end

    // Consume reads the pre-load state; a same-cycle load therefore survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_full <= 1'b0;
            tx_buf  <= '0;
        end else begin
            if (consume) tx_full <= 1'b0;
            if (load_ok) begin
                tx_full <= 1'b1;
                tx_buf  <= tx_data;
            end
        end
    end

`ifdef SPI_SLAVE_UNDERRUN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 tx_underrun <= 1'b0;
        else if (consume & ~tx_full) tx_underrun <= 1'b1;
        else if (load_ok)           tx_underrun <= 1'b0;
    end
`endif

    assign tx_ready = ~tx_full;
    assign miso_oe  = ~cs_sync;
    assign busy     = (state == SHIFT);
endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: table of single-byte frames plus multi-byte, abort, collision and reset sequences.
module tb_spi_slave;
    logic       clk = 1'b0;
    logic       rst_n, sck, cs_n, mosi, tx_load;
    logic [7:0] tx_data, rx_data;
    logic       miso, miso_oe, tx_ready, rx_valid, busy;
`ifdef SPI_SLAVE_UNDERRUN_EN
    logic       tx_underrun;
`endif

    spi_slave #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .sck(sck), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_load(tx_load),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
`ifdef SPI_SLAVE_UNDERRUN_EN
        , .tx_underrun(tx_underrun)
`endif
    );

    always #5 clk = ~clk;

    int         pass_cnt = 0, tot_cnt = 0;
    int         rx_cnt = 0;
    logic [7:0] rx_last = 8'h00, rx_prev = 8'h00;

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_cnt  <= rx_cnt + 1;
            rx_prev <= rx_last;
            rx_last <= rx_data;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_tx(input logic [7:0] d);
        tx_data = d;
        tx_load = 1'b1;
        clk_wait(1);
        tx_load = 1'b0;
    endtask

    task automatic cs_start();
        cs_n = 1'b0;
        clk_wait(10);
    endtask

    task automatic cs_end();
        clk_wait(10);
        cs_n = 1'b1;
        clk_wait(10);
    endtask

    // Master side: 10-clk half periods, miso sampled just before each rise.
    task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            mosi = mo[i];
            clk_wait(10);
            mi[i] = miso;
            sck = 1'b1;
            clk_wait(10);
            sck = 1'b0;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " miso"}, miso, 1'b0);
        chk({tag, " miso_oe"}, miso_oe, 1'b0);
        chk({tag, " tx_ready"}, tx_ready, 1'b1);
        chk({tag, " rx_data"}, rx_data, 8'h00);
        chk({tag, " rx_valid"}, rx_valid, 1'b0);
        chk({tag, " busy"}, busy, 1'b0);
`ifdef SPI_SLAVE_UNDERRUN_EN
        chk({tag, " underrun"}, tx_underrun, 1'b0);
`endif
    endtask

    typedef struct {
        logic       do_load;
        logic [7:0] load;
        logic [7:0] mo;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t       vecs[4];
    logic [7:0] mi0, mi1;
    int         cnt0;

    initial begin
        vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vecs[1] = '{1'b0, 8'h00, 8'hC3, 8'h00, 8'hC3};
        vecs[2] = '{1'b1, 8'hFF, 8'h00, 8'hFF, 8'h00};
        vecs[3] = '{1'b1, 8'h01, 8'h80, 8'h01, 8'h80};

        rst_n = 1'b0; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        tx_load = 1'b0; tx_data = 8'h00;
        clk_wait(3);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        clk_wait(5);

        foreach (vecs[k]) begin
            if (vecs[k].do_load) begin
                load_tx(vecs[k].load);
                chk($sformatf("v%0d tx_ready after load", k), tx_ready, 1'b0);
`ifdef SPI_SLAVE_UNDERRUN_EN
                chk($sformatf("v%0d underrun cleared", k), tx_underrun, 1'b0);
`endif
            end
            cnt0 = rx_cnt;
            cs_start();
            chk($sformatf("v%0d tx_ready at cs_fall", k), tx_ready, 1'b1);
            chk($sformatf("v%0d busy", k), busy, 1'b1);
            chk($sformatf("v%0d miso_oe", k), miso_oe, 1'b1);
            xfer(vecs[k].mo, 8, mi0);
            cs_end();
            chk($sformatf("v%0d miso byte", k), mi0, vecs[k].exp_miso);
            chk($sformatf("v%0d rx_data", k), rx_data, vecs[k].exp_rx);
            chk($sformatf("v%0d rx pulses", k), rx_cnt - cnt0, 1);
            chk($sformatf("v%0d idle miso", k), miso, 1'b0);
            chk($sformatf("v%0d idle busy", k), busy, 1'b0);
`ifdef SPI_SLAVE_UNDERRUN_EN
            chk($sformatf("v%0d underrun", k), tx_underrun, 1'b1);
`endif
        end

        // Two bytes under one cs_n
        load_tx(8'h11);
        cnt0 = rx_cnt;
        cs_start();
        chk("two tx_ready after start", tx_ready, 1'b1);
        load_tx(8'h22);
        chk("two tx_ready after 2nd load", tx_ready, 1'b0);
        xfer(8'hAA, 8, mi0);
        xfer(8'h55, 8, mi1);
        cs_end();
        chk("two miso byte0", mi0, 8'h11);
        chk("two miso byte1", mi1, 8'h22);
        chk("two rx pulses", rx_cnt - cnt0, 2);
        chk("two rx first", rx_prev, 8'hAA);
        chk("two rx second", rx_last, 8'h55);

        // Abort after 5 rises; buffer loaded mid-frame must survive
        cnt0 = rx_cnt;
        cs_start();
        load_tx(8'h77);
        xfer(8'hF0, 5, mi0);
        cs_end();
        chk("abort rx pulses", rx_cnt - cnt0, 0);
        chk("abort rx_data", rx_data, 8'h55);
        chk("abort miso", miso, 1'b0);
        chk("abort miso_oe", miso_oe, 1'b0);
        chk("abort busy", busy, 1'b0);
        chk("abort buffer kept", tx_ready, 1'b0);
        cnt0 = rx_cnt;
        cs_start();
        xfer(8'h96, 8, mi0);
        cs_end();
        chk("post-abort miso", mi0, 8'h77);
        chk("post-abort rx_data", rx_data, 8'h96);
        chk("post-abort rx pulses", rx_cnt - cnt0, 1);

        // Collision: load lands on the same cycle cs_fall consumes the empty buffer
        chk("coll buffer empty", tx_ready, 1'b1);
        cs_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        tx_data = 8'h5A;
        tx_load = 1'b1;
        clk_wait(1);
        tx_load = 1'b0;
        clk_wait(8);
        chk("coll busy", busy, 1'b1);
        chk("coll tx_ready held", tx_ready, 1'b0);
`ifdef SPI_SLAVE_UNDERRUN_EN
        chk("coll underrun set wins", tx_underrun, 1'b1);
`endif
        xfer(8'h12, 8, mi0);
        chk("coll tx_ready before byte2", tx_ready, 1'b0);
        xfer(8'h34, 8, mi1);
        cs_end();
        chk("coll byte0", mi0, 8'h00);
        chk("coll byte1", mi1, 8'h5A);
        chk("coll tx_ready after", tx_ready, 1'b1);
        chk("coll rx_data", rx_data, 8'h34);

        // Reset in the middle of a frame
        load_tx(8'h99);
        cnt0 = rx_cnt;
        cs_start();
        xfer(8'hB4, 4, mi0);
        clk_wait(3);
        rst_n = 1'b0;
        clk_wait(2);
        chk_reset_outputs("midrst");
        chk("midrst rx pulses", rx_cnt - cnt0, 0);
        cs_n = 1'b1;
        clk_wait(3);
        rst_n = 1'b1;
        clk_wait(5);
        chk("midrst idle busy", busy, 1'b0);
        chk("midrst tx_ready", tx_ready, 1'b1);
        load_tx(8'h42);
        cnt0 = rx_cnt;
        cs_start();
        xfer(8'h24, 8, mi0);
        cs_end();
        chk("post-rst miso", mi0, 8'h42);
        chk("post-rst rx_data", rx_data, 8'h24);
        chk("post-rst rx pulses", rx_cnt - cnt0, 1);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
